// File: rtl/calc_operand_ctrl.sv
// Operand sequencer for an external add_subtract datapath.
// Holds the adder inputs stable for SETTLE cycles, then registers the sum and flags.
module calc_operand_ctrl #(
   parameter int N      = 32,
   parameter int SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_a,
   input  logic [N-1:0] in_b,
   input  logic         in_op,
   output logic [N-1:0] as_a,
   output logic [N-1:0] as_b,
   output logic         as_flag,
   output logic         as_cin,
   input  logic [N-1:0] as_s,
   input  logic         as_cout,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         out_carry,
   output logic         out_overflow,
   output logic         out_zero,
   output logic [15:0]  op_count
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] SETTLE_C = 4'(SETTLE);

   logic [1:0]   state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         flag_q, flag_d;
   logic [N-1:0] res_q, res_d;
   logic         carry_q, carry_d;
   logic         ovf_q, ovf_d;
   logic         zero_q, zero_d;
   logic [15:0]  cnt_ops_q, cnt_ops_d;

   logic accept;
   logic consume;
   logic capture;
   logic ovf_now;

   assign in_ready  = rst_n &
                      ((state_q == IDLE) |
                       ((state_q == DONE) & out_ready));
   assign out_valid = rst_n & (state_q == DONE);

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;
   assign capture = (state_q == EXEC) & (cnt_q == 4'd1);

   // Overflow is judged on the registered operands the adder actually saw.
   always_comb begin
      ovf_now = 1'b0;
      if (flag_q)
         ovf_now = (a_q[N-1] == b_q[N-1]) &
                   (as_s[N-1] != a_q[N-1]);
      else
         ovf_now = (a_q[N-1] != b_q[N-1]) &
                   (as_s[N-1] != a_q[N-1]);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      flag_d    = flag_q;
      res_d     = res_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      cnt_ops_d = cnt_ops_q;

      unique case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            if (capture) begin
               state_d = DONE;
               res_d   = as_s;
               carry_d = as_cout;
               ovf_d   = ovf_now;
               zero_d  = (as_s == '0);
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (out_ready) state_d = accept ? EXEC : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         a_d    = in_a;
         b_d    = in_b;
         flag_d = in_op;
         cnt_d  = SETTLE_C;
      end

      if (consume && cnt_ops_q != 16'hFFFF)
         cnt_ops_d = cnt_ops_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         flag_q    <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         ovf_q     <= 1'b0;
         zero_q    <= 1'b0;
         cnt_ops_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         flag_q    <= flag_d;
         res_q     <= res_d;
         carry_q   <= carry_d;
         ovf_q     <= ovf_d;
         zero_q    <= zero_d;
         cnt_ops_q <= cnt_ops_d;
      end
   end

   assign as_a         = a_q;
   assign as_b         = b_q;
   assign as_flag      = flag_q;
   assign as_cin       = 1'b0;
   assign out_result   = res_q;
   assign out_carry    = carry_q;
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q;
   assign op_count     = cnt_ops_q;

endmodule
